// File: rtl/boa_pkg.sv
// -----------------------------------------------------------------------------
// boa_pkg
// Shared types and helpers for the boa32 core.
//
// Contents:
//   boa_arb_owner_t  owner of a shared port (none / fetch / data)
//   BOA_STREAK_W     width of the arbiter streak counter
//   boa_streak_inc   saturating increment of a streak counter
// -----------------------------------------------------------------------------
package boa_pkg;

  // Encoding is visible on the m_owner debug port: 0 none, 1 fetch, 2 data.
  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_P    = 2'd1,
    ARB_D    = 2'd2
  } boa_arb_owner_t;

  localparam int unsigned BOA_STREAK_W = 4;

  typedef logic [BOA_STREAK_W-1:0] boa_streak_t;

  localparam boa_streak_t BOA_STREAK_SAT = '1;

  // Saturates at all-ones so an unlimited configuration never wraps back to 0.
  function automatic boa_streak_t boa_streak_inc(input boa_streak_t v);
    return (v == BOA_STREAK_SAT) ? v : v + boa_streak_t'(1);
  endfunction

endpackage : boa_pkg

// File: rtl/boa_arb_pick.sv
// -----------------------------------------------------------------------------
// boa_arb_pick
// Combinational two-way pick between a fetch (P) and a data (D) requester.
// Used only when the port is not locked; the caller handles ownership.
//
// The "default" side wins a tie unless it has already been granted
// streak_max times in a row while the other side waited, in which case the
// other side wins once.
//
// Parameters:
//   streak_max  consecutive default-side grants allowed while the other waits
//               (1..15), 0 disables the limiter
//   p_first     1: fetch is the default side, 0: data is the default side
//
// Ports:
//   p_pend   in   fetch request pending
//   d_pend   in   data request pending
//   streak   in   current streak count
//   pick     out  chosen owner (ARB_NONE when nothing is pending)
// -----------------------------------------------------------------------------
module boa_arb_pick
  import boa_pkg::*;
#(
  parameter int unsigned streak_max = 4,
  parameter bit          p_first    = 1'b0
) (
  input  logic           p_pend,
  input  logic           d_pend,
  input  boa_streak_t    streak,
  output boa_arb_owner_t pick
);

  localparam boa_arb_owner_t DEF_SIDE   = p_first ? ARB_P : ARB_D;
  localparam boa_arb_owner_t OTHER_SIDE = p_first ? ARB_D : ARB_P;
  localparam bit             LIMITED    = (streak_max != 0);
  localparam boa_streak_t    LIMIT      = boa_streak_t'(streak_max);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    pick = ARB_NONE;
    if (p_pend && d_pend) begin
      if (LIMITED && (streak == LIMIT)) begin
        pick = OTHER_SIDE;
      end else begin
        pick = DEF_SIDE;
      end
    end else if (p_pend) begin
      pick = ARB_P;
    end else if (d_pend) begin
      pick = ARB_D;
    end
  end

endmodule : boa_arb_pick

// File: rtl/boa_mem_arbiter.sv
// -----------------------------------------------------------------------------
// boa_mem_arbiter
// Shares one memory port between the boa32 fetch (P) and data (D) buses.
// Request-to-target path is purely combinational; once a transaction has
// been presented and the target stalls, the grant is locked to that
// requester until the target completes it. A streak limiter stops the
// default-priority side from starving the other.
//
// Parameters:
//   streak_max  default-side grants allowed in a row while the other waits
//               (1..15), 0 = no limit
//   p_first     1: fetch has default priority, 0: data has default priority
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   p_re, p_addr                fetch request (word address)
//   p_rdata, p_ready            fetch response
//   d_re, d_we, d_addr, d_wdata data request (byte write enables)
//   d_rdata, d_ready            data response
//   m_re, m_we, m_addr, m_wdata target request
//   m_rdata, m_ready            target response
//   m_owner                     debug: current selection (0 none, 1 P, 2 D)
// -----------------------------------------------------------------------------
module boa_mem_arbiter
  import boa_pkg::*;
#(
  parameter int unsigned streak_max = 4,
  parameter bit          p_first    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        p_re,
  input  logic [29:0] p_addr,
  output logic [31:0] p_rdata,
  output logic        p_ready,

  input  logic        d_re,
  input  logic [3:0]  d_we,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,

  output logic        m_re,
  output logic [3:0]  m_we,
  output logic [29:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,

  output logic [1:0]  m_owner
);

  localparam boa_arb_owner_t DEF_SIDE = p_first ? ARB_P : ARB_D;

  boa_arb_owner_t own_q;
  boa_streak_t    streak_q;

  logic           p_req;
  logic           d_req;
  logic           other_pend;
  boa_arb_owner_t pick;
  boa_arb_owner_t sel;
  logic           sel_ready;

  // Fetch is read-only; a data write with d_re low is still a request.
  assign p_req = p_re;
  assign d_req = d_re | (|d_we);

  // Pending flag of the side the limiter protects.
  assign other_pend = p_first ? d_req : p_req;

  boa_arb_pick #(
    .streak_max (streak_max),
    .p_first    (p_first)
  ) u_pick (
    .p_pend (p_req),
    .d_pend (d_req),
    .streak (streak_q),
    .pick   (pick)
  );

  // A locked owner overrides the pick until its transaction completes.
  assign sel       = (own_q != ARB_NONE) ? own_q : pick;
  assign sel_ready = m_ready && (sel != ARB_NONE);

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  logic        fwd_re;
  logic [3:0]  fwd_we;
  logic [29:0] fwd_addr;
  logic [31:0] fwd_wdata;

  always_comb begin
    fwd_re    = 1'b0;
    fwd_we    = '0;
    fwd_addr  = '0;
    fwd_wdata = '0;
    unique case (sel)
      ARB_P: begin
        fwd_re   = p_re;
        fwd_addr = p_addr;
      end
      ARB_D: begin
        fwd_re    = d_re;
        fwd_we    = d_we;
        fwd_addr  = d_addr;
        fwd_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  // Outputs are gated by rst_n so they drop the moment reset asserts,
  // without waiting for the registers or a clock edge.
  assign m_re    = fwd_re & rst_n;
  assign m_we    = fwd_we & {4{rst_n}};
  assign m_addr  = fwd_addr & {30{rst_n}};
  assign m_wdata = fwd_wdata & {32{rst_n}};
  assign m_owner = sel & {2{rst_n}};

  assign p_ready = sel_ready && (sel == ARB_P) && rst_n;
  assign d_ready = sel_ready && (sel == ARB_D) && rst_n;

  assign p_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // ---------------------------------------------------------------------------
  // Lock and streak state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q    <= ARB_NONE;
      streak_q <= '0;
    end else begin
      // Only a stalled transaction locks; zero-wait ones re-arbitrate next
      // cycle with no bubble.
      if ((sel != ARB_NONE) && !m_ready) begin
        own_q <= sel;
      end else begin
        own_q <= ARB_NONE;
      end

      if (sel_ready) begin
        if ((sel == DEF_SIDE) && other_pend) begin
          streak_q <= boa_streak_inc(streak_q);
        end else begin
          streak_q <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checks: the locked requester must hold its request stable.
  // ---------------------------------------------------------------------------
  a_p_hold : assert property (
    @(posedge clk) disable iff (!rst_n)
      (own_q == ARB_P) |-> ($stable(p_re) && $stable(p_addr))
  );

  a_d_hold : assert property (
    @(posedge clk) disable iff (!rst_n)
      (own_q == ARB_D) |-> ($stable(d_re) && $stable(d_we) &&
                            $stable(d_addr) && $stable(d_wdata))
  );

endmodule : boa_mem_arbiter

// File: tb/tb_boa_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_boa_mem_arbiter
// Directed bench for boa_mem_arbiter. Two instances share the stimulus:
//   dut     default configuration (data first, streak_max = 4)
//   dut_pf  fetch first, no streak limit
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled 1 time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_boa_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p_re;
  logic [29:0] p_addr;
  logic        d_re;
  logic [3:0]  d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  logic [31:0] p_rdata, d_rdata, m_wdata;
  logic        p_ready, d_ready, m_re;
  logic [3:0]  m_we;
  logic [29:0] m_addr;
  logic [1:0]  m_owner;

  logic [31:0] pf_p_rdata, pf_d_rdata, pf_m_wdata;
  logic        pf_p_ready, pf_d_ready, pf_m_re;
  logic [3:0]  pf_m_we;
  logic [29:0] pf_m_addr;
  logic [1:0]  pf_m_owner;

  int n_checks = 0;
  int n_errors = 0;

  boa_mem_arbiter #(.streak_max(4), .p_first(1'b0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .p_re    (p_re),
    .p_addr  (p_addr),
    .p_rdata (p_rdata),
    .p_ready (p_ready),
    .d_re    (d_re),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .m_re    (m_re),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .m_owner (m_owner)
  );

  boa_mem_arbiter #(.streak_max(0), .p_first(1'b1)) dut_pf (
    .clk     (clk),
    .rst_n   (rst_n),
    .p_re    (p_re),
    .p_addr  (p_addr),
    .p_rdata (pf_p_rdata),
    .p_ready (pf_p_ready),
    .d_re    (d_re),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (pf_d_rdata),
    .d_ready (pf_d_ready),
    .m_re    (pf_m_re),
    .m_we    (pf_m_we),
    .m_addr  (pf_m_addr),
    .m_wdata (pf_m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .m_owner (pf_m_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_re    = 1'b0;
    p_addr  = '0;
    d_re    = 1'b0;
    d_we    = '0;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  // Streak test: grant sequence and streak after each completion.
  logic [1:0] exp_own [6] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};
  logic [3:0] exp_stk [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    m_rdata = '0;
    m_ready = 1'b1;
    idle();
    p_re   = 1'b1;
    p_addr = 30'h55;

    // Reset: outputs gated even with a request present and target ready.
    #12;
    check("rst_m_re", 32'(m_re), 32'd0);
    check("rst_m_addr", 32'(m_addr), 32'd0);
    check("rst_p_ready", 32'(p_ready), 32'd0);
    check("rst_owner", 32'(m_owner), 32'd0);
    check("rst_streak", 32'(dut.streak_q), 32'd0);
    check("rst_own", 32'(dut.own_q), 32'd0);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single fetch, zero-wait.
    p_re = 1'b1; p_addr = 30'h100; m_ready = 1'b1; m_rdata = 32'hCAFE_0001;
    #1;
    check("t1_m_addr", 32'(m_addr), 32'h100);
    check("t1_m_re", 32'(m_re), 32'd1);
    check("t1_p_ready", 32'(p_ready), 32'd1);
    check("t1_p_rdata", p_rdata, 32'hCAFE_0001);
    check("t1_d_ready", 32'(d_ready), 32'd0);
    check("t1_owner", 32'(m_owner), 32'd1);
    tick();
    check("t1_own_none", 32'(dut.own_q), 32'd0);

    // Both request, target stalls 3 cycles: data granted and locked.
    p_re = 1'b1; p_addr = 30'h100;
    d_we = 4'hF; d_addr = 30'h200; d_wdata = 32'h1234_5678;
    m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t3_owner", 32'(m_owner), 32'd2);
      check("t3_m_addr", 32'(m_addr), 32'h200);
      check("t3_m_we", 32'(m_we), 32'hF);
      check("t3_m_wdata", m_wdata, 32'h1234_5678);
      check("t3_d_ready", 32'(d_ready), 32'd0);
      check("t3_p_ready", 32'(p_ready), 32'd0);
      tick();
    end
    m_ready = 1'b1; m_rdata = 32'hA5A5_0004;
    #1;
    check("t3_c4_d_ready", 32'(d_ready), 32'd1);
    check("t3_c4_d_rdata", d_rdata, 32'hA5A5_0004);
    check("t3_c4_m_addr", 32'(m_addr), 32'h200);
    check("t3_c4_p_ready", 32'(p_ready), 32'd0);
    tick();
    d_we = 4'h0; d_addr = '0; d_wdata = '0;
    #1;
    check("t3_c5_owner", 32'(m_owner), 32'd1);
    check("t3_c5_p_ready", 32'(p_ready), 32'd1);
    check("t3_c5_m_addr", 32'(m_addr), 32'h100);
    check("t3_c5_streak", 32'(dut.streak_q), 32'd1);
    tick();
    check("t3_streak_clr", 32'(dut.streak_q), 32'd0);

    // Streak limiter: p_re held, back-to-back zero-wait data reads.
    p_re = 1'b1; d_re = 1'b1; d_addr = 30'h3F0; m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t4_owner%0d", i), 32'(m_owner), 32'(exp_own[i]));
      check($sformatf("t4_d_ready%0d", i), 32'(d_ready), 32'(exp_own[i] == 2'd2));
      check($sformatf("t4_p_ready%0d", i), 32'(p_ready), 32'(exp_own[i] == 2'd1));
      tick();
      check($sformatf("t4_streak%0d", i), 32'(dut.streak_q), 32'(exp_stk[i]));
    end

    // Lock holds D while fetch raises its request.
    p_re = 1'b0; d_re = 1'b1; d_addr = 30'h300; m_ready = 1'b0;
    #1;
    check("t5_owner", 32'(m_owner), 32'd2);
    tick();
    check("t5_own_d", 32'(dut.own_q), 32'd2);
    p_re = 1'b1; p_addr = 30'h104;
    #1;
    check("t5_lock_owner", 32'(m_owner), 32'd2);
    check("t5_lock_m_addr", 32'(m_addr), 32'h300);
    check("t5_lock_p_ready", 32'(p_ready), 32'd0);
    tick();
    m_ready = 1'b1;
    #1;
    check("t5_d_ready", 32'(d_ready), 32'd1);
    tick();
    check("t5_streak", 32'(dut.streak_q), 32'd2);
    d_re = 1'b0; d_addr = '0;
    #1;
    check("t5_p_owner", 32'(m_owner), 32'd1);
    check("t5_p_ready", 32'(p_ready), 32'd1);
    tick();
    check("t5_streak_clr", 32'(dut.streak_q), 32'd0);

    // Reset mid-transaction with fetch locked.
    p_re = 1'b1; p_addr = 30'h140; d_re = 1'b0; m_ready = 1'b0;
    #1;
    check("t6_owner_p", 32'(m_owner), 32'd1);
    tick();
    check("t6_own_p", 32'(dut.own_q), 32'd1);
    d_re = 1'b1; d_addr = 30'h2C0;
    #1;
    check("t6_locked_p", 32'(m_owner), 32'd1);
    rst_n = 1'b0; m_ready = 1'b1;
    #1;
    check("t6_m_re", 32'(m_re), 32'd0);
    check("t6_m_addr", 32'(m_addr), 32'd0);
    check("t6_owner0", 32'(m_owner), 32'd0);
    check("t6_p_ready", 32'(p_ready), 32'd0);
    check("t6_d_ready", 32'(d_ready), 32'd0);
    check("t6_own_none", 32'(dut.own_q), 32'd0);
    check("t6_streak0", 32'(dut.streak_q), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_post_owner", 32'(m_owner), 32'd2);
    check("t6_post_d_ready", 32'(d_ready), 32'd1);
    check("t6_post_m_addr", 32'(m_addr), 32'h2C0);
    check("t6_post_p_ready", 32'(p_ready), 32'd0);
    tick();

    // Fetch-first, unlimited: fetch wins every cycle.
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    p_re = 1'b1; p_addr = 30'h180; d_re = 1'b1; d_addr = 30'h280; m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      check($sformatf("t7_owner%0d", i), 32'(pf_m_owner), 32'd1);
      check($sformatf("t7_p_ready%0d", i), 32'(pf_p_ready), 32'd1);
      check($sformatf("t7_d_ready%0d", i), 32'(pf_d_ready), 32'd0);
      check($sformatf("t7_m_addr%0d", i), 32'(pf_m_addr), 32'h180);
      tick();
    end
    check("t7_streak_sat", 32'(dut_pf.streak_q), 32'd15);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_boa_mem_arbiter
